// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bundle between the command master and the accelerator's control register slave.
interface axil_cmd_master_if;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master: single write/read commands plus a masked-compare poll with retry limit.
module axil_cmd_master #(
  parameter int POLL_MAX = 1024,
  parameter int POLL_GAP = 4
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  input  logic [31:0] cmd_mask,
  input  logic [31:0] cmd_match,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  axil_cmd_master_if.master M_AXI
);
  localparam int ACW = $clog2(POLL_MAX) + 1;
  localparam int GW  = $clog2(POLL_GAP + 2);
  localparam logic [ACW-1:0] ATT_LAST = ACW'(POLL_MAX - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, GAP} state_e;

  state_e         state_q, state_d;
  logic [31:0]    addr_q, addr_d, wdata_q, wdata_d, mask_q, mask_d, match_q, match_d;
  logic [3:0]     wstrb_q, wstrb_d;
  logic           poll_q, poll_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ACW-1:0] att_q, att_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [31:0]    rsp_rdata_q, rsp_rdata_d;
  logic [1:0]     rsp_resp_q, rsp_resp_d;
  logic           aw_hs, w_hs, hit, last_att, unused_addr_lsb;

  assign aw_hs    = (state_q == WR) && !aw_done_q && M_AXI.AWREADY;
  assign w_hs     = (state_q == WR) && !w_done_q && M_AXI.WREADY;
  assign hit      = ((M_AXI.RDATA & mask_q) == match_q);
  assign last_att = (att_q == ATT_LAST);
  assign unused_addr_lsb = ^cmd_addr[1:0];

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      addr_q <= '0; wdata_q <= '0; wstrb_q <= '0; mask_q <= '0; match_q <= '0;
      poll_q <= 1'b0; aw_done_q <= 1'b0; w_done_q <= 1'b0; att_q <= '0; gap_q <= '0;
      rsp_valid_q <= 1'b0; rsp_rdata_q <= '0; rsp_resp_q <= '0; rsp_timeout_q <= 1'b0;
    end else begin
      addr_q <= addr_d; wdata_q <= wdata_d; wstrb_q <= wstrb_d; mask_q <= mask_d; match_q <= match_d;
      poll_q <= poll_d; aw_done_q <= aw_done_d; w_done_q <= w_done_d; att_q <= att_d; gap_q <= gap_d;
      rsp_valid_q <= rsp_valid_d; rsp_rdata_q <= rsp_rdata_d; rsp_resp_q <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d = addr_q; wdata_d = wdata_q; wstrb_d = wstrb_q; mask_d = mask_q; match_d = match_q;
    poll_d = poll_q; aw_done_d = aw_done_q; w_done_d = w_done_q; att_d = att_q; gap_d = gap_q;
    rsp_valid_d = 1'b0; rsp_rdata_d = rsp_rdata_q; rsp_resp_d = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d    = {cmd_addr[31:2], 2'b00};
        wdata_d   = cmd_wdata;
        wstrb_d   = cmd_wstrb;
        mask_d    = cmd_mask;
        match_d   = cmd_match;
        poll_d    = (cmd_op == 2'd2);
        att_d     = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = (cmd_op == 2'd0) ? WR : RA;
      end
      WR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = WB;
      end
      WB: if (M_AXI.BVALID) begin
        rsp_valid_d   = 1'b1;
        rsp_resp_d    = M_AXI.BRESP;
        rsp_rdata_d   = '0;
        rsp_timeout_d = 1'b0;
        state_d       = IDLE;
      end
      RA: if (M_AXI.ARREADY) state_d = RD;
      RD: if (M_AXI.RVALID) begin
        rsp_rdata_d = M_AXI.RDATA;
        rsp_resp_d  = M_AXI.RRESP;
        // Slave error or match ends a poll early; only a clean miss on the last try is a timeout.
        if (!poll_q || M_AXI.RRESP[1] || hit || last_att) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = poll_q && !M_AXI.RRESP[1] && !hit && last_att;
          state_d       = IDLE;
        end else begin
          att_d   = att_q + 1'b1;
          gap_d   = '0;
          state_d = (POLL_GAP == 0) ? RA : GAP;
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) state_d = RA;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = (state_q == IDLE);
    M_AXI.AWVALID = (state_q == WR) && !aw_done_q;
    M_AXI.WVALID  = (state_q == WR) && !w_done_q;
    M_AXI.BREADY  = (state_q == WB);
    M_AXI.ARVALID = (state_q == RA);
    M_AXI.RREADY  = (state_q == RD);
    M_AXI.AWADDR  = addr_q;
    M_AXI.ARADDR  = addr_q;
    M_AXI.WDATA   = wdata_q;
    M_AXI.WSTRB   = wstrb_q;
    rsp_valid     = rsp_valid_q;
    rsp_rdata     = rsp_rdata_q;
    rsp_resp      = rsp_resp_q;
    rsp_timeout   = rsp_timeout_q;
  end
endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench: AXI-Lite slave model with per-channel ready delays, self-clearing matw bit and error injection.
module tb_axil_cmd_master;
  localparam int PM = 8;
  localparam int PG = 4;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 gclk = ~gclk;

  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_wdata, cmd_mask, cmd_match;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  axil_cmd_master_if M_AXI();

  axil_cmd_master #(.POLL_MAX(PM), .POLL_GAP(PG)) dut (
    .M_AXI_ACLK(gclk), .M_AXI_ARESETN(grst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask), .cmd_match(cmd_match),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI(M_AXI)
  );

  // ---------------- slave model ----------------
  int aw_lat = 0, w_lat = 0, err_at = -1, clr_delay = 0;
  int aw_cnt, w_cnt, ar_cnt, matw_cnt;
  logic aw_got, w_got, r_wait, bvalid_s, rvalid_s;
  logic [31:0] aw_addr_s, r_addr_s, w_data_s, rdata_s;
  logic [3:0]  w_strb_s;
  logic [1:0]  rresp_s;
  logic [31:0] mem [16];
  logic aw_hs_s, w_hs_s, aw_have, w_have;
  logic [31:0] awa, wd;
  logic [3:0]  ws;

  assign M_AXI.AWREADY = M_AXI.AWVALID && !aw_got && (aw_cnt >= aw_lat);
  assign M_AXI.WREADY  = M_AXI.WVALID && !w_got && (w_cnt >= w_lat);
  assign M_AXI.ARREADY = M_AXI.ARVALID && !r_wait && !rvalid_s;
  assign M_AXI.BVALID  = bvalid_s;
  assign M_AXI.BRESP   = 2'b00;
  assign M_AXI.RVALID  = rvalid_s;
  assign M_AXI.RDATA   = rdata_s;
  assign M_AXI.RRESP   = rresp_s;
  assign aw_hs_s = M_AXI.AWVALID && M_AXI.AWREADY;
  assign w_hs_s  = M_AXI.WVALID && M_AXI.WREADY;
  assign aw_have = aw_got || aw_hs_s;
  assign w_have  = w_got || w_hs_s;
  assign awa = aw_got ? aw_addr_s : M_AXI.AWADDR;
  assign wd  = w_got ? w_data_s : M_AXI.WDATA;
  assign ws  = w_got ? w_strb_s : M_AXI.WSTRB;

  always @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; matw_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_wait <= 1'b0; bvalid_s <= 1'b0; rvalid_s <= 1'b0;
      aw_addr_s <= '0; r_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0; rdata_s <= '0; rresp_s <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (aw_hs_s) aw_cnt <= 0; else if (M_AXI.AWVALID) aw_cnt <= aw_cnt + 1;
      if (w_hs_s) w_cnt <= 0; else if (M_AXI.WVALID) w_cnt <= w_cnt + 1;
      if (aw_hs_s) begin aw_got <= 1'b1; aw_addr_s <= M_AXI.AWADDR; end
      if (w_hs_s) begin w_got <= 1'b1; w_data_s <= M_AXI.WDATA; w_strb_s <= M_AXI.WSTRB; end
      if (matw_cnt > 0) begin
        matw_cnt <= matw_cnt - 1;
        if (matw_cnt == 1) mem[0][0] <= 1'b0;
      end
      if (aw_have && w_have && !bvalid_s) begin
        for (int b = 0; b < 4; b++) if (ws[b]) mem[awa[5:2]][8*b +: 8] <= wd[8*b +: 8];
        bvalid_s <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
        if (awa[5:2] == 4'd0 && ws[0] && wd[0] && clr_delay > 0) matw_cnt <= clr_delay;
      end
      if (bvalid_s && M_AXI.BREADY) bvalid_s <= 1'b0;
      if (M_AXI.ARVALID && M_AXI.ARREADY) begin
        r_wait <= 1'b1; r_addr_s <= M_AXI.ARADDR; ar_cnt <= ar_cnt + 1;
      end
      if (r_wait) begin
        r_wait <= 1'b0; rvalid_s <= 1'b1; rdata_s <= mem[r_addr_s[5:2]];
        rresp_s <= (ar_cnt == err_at) ? 2'b10 : 2'b00;
      end
      if (rvalid_s && M_AXI.RREADY) rvalid_s <= 1'b0;
    end
  end

  // ---------------- recorder ----------------
  int total = 0, bad = 0;
  int rsp_cyc, aw_n, w_n, aw_first, aw_last, w_first, w_last, b_n, r_n, ar_n, overlap_n, ar_hs_n;
  int ar_hs_c [2];
  logic [31:0] got_rdata, ar_addr_seen;
  logic [1:0]  got_resp;
  logic got_to, rsp_after, ready_at_rsp, to_flag, acc_ok;

  task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] mask, input logic [31:0] match);
    int cyc;
    bit got;
    aw_n = 0; w_n = 0; aw_first = 0; aw_last = 0; w_first = 0; w_last = 0; b_n = 0; r_n = 0;
    ar_n = 0; overlap_n = 0; ar_hs_n = 0; ar_hs_c[0] = 0; ar_hs_c[1] = 0; rsp_cyc = 0;
    ar_addr_seen = '0;
    @(negedge gclk);
    acc_ok = cmd_ready;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb;
    cmd_mask = mask; cmd_match = match;
    @(negedge gclk);
    cmd_valid = 1'b0;
    cyc = 1; got = 0;
    while (!got && cyc <= 2000) begin
      if (M_AXI.AWVALID) begin aw_n++; if (aw_first == 0) aw_first = cyc; aw_last = cyc; end
      if (M_AXI.WVALID) begin w_n++; if (w_first == 0) w_first = cyc; w_last = cyc; end
      if (M_AXI.BREADY) b_n++;
      if (M_AXI.RREADY) r_n++;
      if (M_AXI.ARVALID) begin ar_n++; ar_addr_seen = M_AXI.ARADDR; end
      if (M_AXI.ARVALID && M_AXI.ARREADY) begin
        if (ar_hs_n < 2) ar_hs_c[ar_hs_n] = cyc;
        ar_hs_n++;
      end
      if ((M_AXI.AWVALID || M_AXI.WVALID || M_AXI.BREADY) && (M_AXI.ARVALID || M_AXI.RREADY))
        overlap_n++;
      if (rsp_valid) begin
        got = 1; rsp_cyc = cyc; got_rdata = rsp_rdata; got_resp = rsp_resp; got_to = rsp_timeout;
        ready_at_rsp = cmd_ready;
      end else begin
        @(negedge gclk); cyc++;
      end
    end
    to_flag = !got;
    @(negedge gclk);
    rsp_after = rsp_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    grst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    cmd_mask = '0; cmd_match = '0;
    repeat (3) @(negedge gclk);
    grst_n = 1'b1;
    @(negedge gclk);
    total++;
    if ({cmd_ready, M_AXI.AWVALID, M_AXI.WVALID, M_AXI.BREADY, M_AXI.ARVALID, M_AXI.RREADY,
         rsp_valid, rsp_timeout} !== 8'b1000_0000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 10000000", {cmd_ready, M_AXI.AWVALID,
        M_AXI.WVALID, M_AXI.BREADY, M_AXI.ARVALID, M_AXI.RREADY, rsp_valid, rsp_timeout});
    end
    total++;
    if ({rsp_rdata, rsp_resp, M_AXI.AWADDR, M_AXI.WDATA, M_AXI.ARADDR} !== '0) begin
      bad++; $display("FAIL reset_data: rdata=%h resp=%h awaddr=%h wdata=%h, want all 0",
        rsp_rdata, rsp_resp, M_AXI.AWADDR, M_AXI.WDATA);
    end
  endtask

  task automatic test_write_basic();
    aw_lat = 0; w_lat = 0;
    run_cmd(2'd0, 32'h0, 32'h2, 4'hF, '0, '0);
    total++;
    if (to_flag !== 1'b0 || acc_ok !== 1'b1) begin
      bad++; $display("FAIL wr_basic_done: timeout=%b accepted=%b want 0/1", to_flag, acc_ok);
    end
    total++;
    if (aw_n != 1 || aw_first != 1 || w_n != 1 || w_first != 1) begin
      bad++; $display("FAIL wr_basic_valids: aw %0d@%0d w %0d@%0d want 1@1 each",
        aw_n, aw_first, w_n, w_first);
    end
    total++;
    if (rsp_cyc != 3 || b_n != 1) begin
      bad++; $display("FAIL wr_basic_latency: rsp cyc %0d bready cycles %0d want 3/1", rsp_cyc, b_n);
    end
    total++;
    if (got_resp !== 2'b00 || got_rdata !== 32'h0 || got_to !== 1'b0) begin
      bad++; $display("FAIL wr_basic_rsp: resp=%h rdata=%h to=%b want 0/0/0", got_resp, got_rdata, got_to);
    end
    total++;
    if (rsp_after !== 1'b0 || ready_at_rsp !== 1'b1) begin
      bad++; $display("FAIL wr_basic_pulse: after=%b ready=%b want 0/1", rsp_after, ready_at_rsp);
    end
    total++;
    if (mem[0] !== 32'h2) begin
      bad++; $display("FAIL wr_basic_mem: got %h want 00000002", mem[0]);
    end
  endtask

  task automatic test_write_skew();
    aw_lat = 3; w_lat = 0;
    run_cmd(2'd0, 32'h10, 32'hDEADBEEF, 4'hF, '0, '0);
    total++;
    if (w_n != 1 || w_last != 1 || aw_n != 4 || aw_last != 4) begin
      bad++; $display("FAIL wr_skew_valids: w %0d last %0d aw %0d last %0d want 1/1/4/4",
        w_n, w_last, aw_n, aw_last);
    end
    total++;
    if (to_flag !== 1'b0 || rsp_cyc != 6 || rsp_after !== 1'b0) begin
      bad++; $display("FAIL wr_skew_rsp: to=%b cyc %0d after=%b want 0/6/0", to_flag, rsp_cyc, rsp_after);
    end
    aw_lat = 0;
    run_cmd(2'd1, 32'h10, '0, '0, '0, '0);
    total++;
    if (got_rdata !== 32'hDEADBEEF || rsp_cyc != 4) begin
      bad++; $display("FAIL wr_skew_readback: got %h cyc %0d want deadbeef/4", got_rdata, rsp_cyc);
    end
  endtask

  task automatic test_read();
    clr_delay = 0;
    run_cmd(2'd0, 32'h0, 32'h5, 4'hF, '0, '0);
    run_cmd(2'd1, 32'h0, '0, '0, '0, '0);
    total++;
    if (got_rdata !== 32'h5 || got_resp !== 2'b00 || got_to !== 1'b0) begin
      bad++; $display("FAIL rd_data: rdata=%h resp=%h to=%b want 5/0/0", got_rdata, got_resp, got_to);
    end
    total++;
    if (rsp_cyc != 4 || rsp_after !== 1'b0 || to_flag !== 1'b0) begin
      bad++; $display("FAIL rd_latency: cyc %0d after=%b want 4/0", rsp_cyc, rsp_after);
    end
    total++;
    if (r_n != 2 || ar_n != 1 || overlap_n != 0) begin
      bad++; $display("FAIL rd_handshake: rready %0d arvalid %0d overlap %0d want 2/1/0", r_n, ar_n, overlap_n);
    end
    run_cmd(2'd3, 32'h13, '0, '0, '0, '0);
    total++;
    if (got_rdata !== 32'hDEADBEEF || ar_addr_seen !== 32'h10) begin
      bad++; $display("FAIL rd_reserved_unaligned: rdata=%h araddr=%h want deadbeef/00000010",
        got_rdata, ar_addr_seen);
    end
  endtask

  task automatic test_poll_match();
    clr_delay = 30;
    run_cmd(2'd0, 32'h0, 32'h1, 4'hF, '0, '0);
    clr_delay = 0;
    run_cmd(2'd2, 32'h0, '0, '0, 32'h1, 32'h0);
    total++;
    if (to_flag !== 1'b0 || got_to !== 1'b0 || got_rdata[0] !== 1'b0 || got_resp !== 2'b00) begin
      bad++; $display("FAIL poll_match_rsp: hang=%b to=%b rdata=%h resp=%h want 0/0/bit0=0/0",
        to_flag, got_to, got_rdata, got_resp);
    end
    total++;
    if (ar_hs_n < 2 || ar_hs_c[1] - ar_hs_c[0] != 3 + PG) begin
      bad++; $display("FAIL poll_match_gap: reads %0d spacing %0d want >=2 and %0d",
        ar_hs_n, ar_hs_c[1] - ar_hs_c[0], 3 + PG);
    end
  endtask

  task automatic test_poll_timeout();
    int n0;
    err_at = -1;
    n0 = ar_cnt;
    run_cmd(2'd2, 32'h4, '0, '0, 32'hFFFFFFFF, 32'h12345678);
    total++;
    if (ar_cnt - n0 != PM || got_to !== 1'b1 || got_resp !== 2'b00 || to_flag !== 1'b0) begin
      bad++; $display("FAIL poll_timeout: reads %0d to=%b resp=%h want %0d/1/0",
        ar_cnt - n0, got_to, got_resp, PM);
    end
    n0 = ar_cnt;
    err_at = n0 + 3;
    run_cmd(2'd2, 32'h4, '0, '0, 32'hFFFFFFFF, 32'h12345678);
    err_at = -1;
    total++;
    if (ar_cnt - n0 != 3 || got_to !== 1'b0 || got_resp !== 2'b10 || to_flag !== 1'b0) begin
      bad++; $display("FAIL poll_error: reads %0d to=%b resp=%h want 3/0/2", ar_cnt - n0, got_to, got_resp);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit got;
    @(negedge gclk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 32'h8; cmd_wdata = 32'h11223344; cmd_wstrb = 4'hF;
    @(negedge gclk);
    cmd_valid = 1'b0;
    got = 0; cyc = 0;
    while (!got && cyc < 100) begin
      if (rsp_valid) got = 1;
      else begin @(negedge gclk); cyc++; end
    end
    total++;
    if (!got || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_write: rsp seen=%b ready=%b want 1/1", got, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 32'h8;
    @(negedge gclk);
    cmd_valid = 1'b0;
    cyc = 1; got = 0;
    while (!got && cyc < 100) begin
      if (rsp_valid) got = 1;
      else begin @(negedge gclk); cyc++; end
    end
    total++;
    if (!got || cyc != 4 || rsp_rdata !== 32'h11223344) begin
      bad++; $display("FAIL b2b_read: seen=%b cyc %0d rdata=%h want 1/4/11223344", got, cyc, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid();
    aw_lat = 5; w_lat = 5;
    @(negedge gclk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 32'hC; cmd_wdata = 32'hA5A5; cmd_wstrb = 4'hF;
    @(negedge gclk);
    cmd_valid = 1'b0;
    @(negedge gclk);
    total++;
    if (M_AXI.AWVALID !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre: awvalid=%b want 1", M_AXI.AWVALID);
    end
    grst_n = 1'b0;
    #1;
    total++;
    if ({M_AXI.AWVALID, M_AXI.WVALID, M_AXI.ARVALID, M_AXI.BREADY, M_AXI.RREADY} !== 5'b0) begin
      bad++; $display("FAIL rst_mid_drop: got %b want 00000", {M_AXI.AWVALID, M_AXI.WVALID,
        M_AXI.ARVALID, M_AXI.BREADY, M_AXI.RREADY});
    end
    @(negedge gclk);
    grst_n = 1'b1;
    @(negedge gclk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_ready: got %b want 1", cmd_ready);
    end
    aw_lat = 0; w_lat = 0;
    run_cmd(2'd0, 32'hC, 32'hA5A5, 4'hF, '0, '0);
    total++;
    if (to_flag !== 1'b0 || rsp_cyc != 3 || mem[3] !== 32'hA5A5) begin
      bad++; $display("FAIL rst_mid_write: to=%b cyc %0d mem=%h want 0/3/0000a5a5", to_flag, rsp_cyc, mem[3]);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_skew();
    test_read();
    test_poll_match();
    test_poll_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
